regbank_write_arbiter: RTL and testbench

//  Round-robin write arbiter for a bank of NUM_REGS WIDTH-bit enabled D-registers.

---
 rtl/regbank_pkg.sv | 38 +++
 rtl/rr_priority_picker.sv | 15 +
 rtl/regbank_write_arbiter.sv | 128 ++++++++++++
 tb/tb_regbank_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and the round-robin pick helper for the register-bank write arbiter.
package regbank_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  // Rotate req so ptr sits at bit 0, take the lowest set bit, rotate the pick back.
  // Only the low n bits take part; n is the real requester count.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] rot;
    logic [MAX_REQ-1:0] res;
    logic               found;
    rot   = '0;
    res   = '0;
    found = 1'b0;
    if (n == 0) return res;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) rot[IDX_W'(i)] = req[IDX_W'((i + ptr) % n)];
    end
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if ((i < n) && !found && rot[IDX_W'(i)]) begin
        res[IDX_W'((i + ptr) % n)] = 1'b1;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: one-hot grant of the first set request at or after i_ptr.
module rr_priority_picker
  import regbank_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  assign o_gnt = NUM_REQ'(rr_pick(MAX_REQ'(i_req), 32'(i_ptr), NUM_REQ));

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port, with lockable bursts
// and a registered one-hot write enable / data bus driving the bank.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned NUM_REGS = 8,
  parameter  int unsigned WIDTH    = 8,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
  localparam int unsigned PTR_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       reg_enable,
  output logic [WIDTH-1:0]          reg_data,
  output logic                      locked
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    w_rr_ptr_nxt;
  logic [PTR_W-1:0]    r_lock_owner;
  logic [PTR_W-1:0]    w_lock_owner_nxt;
  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic                w_xfer;
  logic [PTR_W-1:0]    w_xfer_idx;
  logic [ADDR_W-1:0]   w_xfer_addr;
  logic [WIDTH-1:0]    w_xfer_data;
  logic [NUM_REGS-1:0] w_dec;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
    return (k == PTR_W'(NUM_REQ - 1)) ? '0 : k + PTR_W'(1);
  endfunction

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt)
  );

  // While locked only the owner can be granted; everyone else is blocked.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt = '0;
    if (r_state == ARB) begin
      gnt = w_pick_gnt;
    end else if (req[r_lock_owner]) begin
      gnt[r_lock_owner] = 1'b1;
    end
  end

  assign w_xfer = |(req & gnt);
  assign locked = (r_state == LOCKED);

  always_comb begin
    w_xfer_idx  = '0;
    w_xfer_addr = '0;
    w_xfer_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_xfer_idx  = PTR_W'(i);
        w_xfer_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_xfer_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Out-of-range indices match no register, so the write is silently dropped.
  always_comb begin
    w_dec = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      w_dec[j] = (w_xfer_addr == ADDR_W'(j));
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_lock_owner_nxt = r_lock_owner;
    unique case (r_state)
      ARB: begin
        if (w_xfer) begin
          if (req_lock[w_xfer_idx]) begin
            w_state_nxt      = LOCKED;
            w_lock_owner_nxt = w_xfer_idx;
          end else begin
            w_rr_ptr_nxt = next_idx(w_xfer_idx);
          end
        end
      end
      LOCKED: begin
        // Leaves on an unlocked final transfer or when the owner abandons (req low).
        if (!(req[r_lock_owner] && req_lock[r_lock_owner])) begin
          w_state_nxt  = ARB;
          w_rr_ptr_nxt = next_idx(r_lock_owner);
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB;
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
      reg_enable   <= '0;
      reg_data     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      reg_enable   <= w_xfer ? w_dec : '0;
      if (w_xfer) reg_data <= w_xfer_data;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a behavioural model.
module tb_regbank_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_lock;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  gnt8, gnt6;
  logic [7:0]  en8;
  logic [5:0]  en6;
  logic [7:0]  data8, data6;
  logic        locked8, locked6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regbank_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt8), .reg_enable(en8), .reg_data(data8), .locked(locked8)
  );

  // Six-register bank shares the stimulus; indices 6 and 7 are out of range for it.
  regbank_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .WIDTH(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt6), .reg_enable(en6), .reg_data(data6), .locked(locked6)
  );

  task automatic set_slot(input int i, input logic [2:0] a, input logic [7:0] d);
    req_addr[i*3 +: 3] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic reset_dut();
    req = '0; req_lock = '0; req_addr = '0; req_data = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    req = 4'b0001; req_lock = 4'b0001; set_slot(0, 3'd2, 8'h3C);
    @(posedge clk); #2;
    n_checks++;
    if ({locked8, en8, data8} !== {1'b1, 8'h04, 8'h3C})
      $display("FAIL reset_preload: got %b/%h/%h want 1/04/3c", locked8, en8, data8);
    else n_pass++;
    req = '0; req_lock = '0; rst_n = 1'b0; #1;
    n_checks++;
    if ({gnt8, en8, data8, locked8, gnt6, en6, data6, locked6} !== '0)
      $display("FAIL reset_async: got gnt=%b en=%h data=%h locked=%b want all 0", gnt8, en8, data8, locked8);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({gnt8, en8, locked8} !== '0)
      $display("FAIL reset_idle: got gnt=%b en=%h locked=%b want 0", gnt8, en8, locked8);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single();
    reset_dut();
    req = 4'b0001; set_slot(0, 3'd3, 8'hA5); #1;
    n_checks++;
    if (gnt8 !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt8); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({en8, data8} !== {8'h08, 8'hA5}) $display("FAIL single_write: got %h/%h want 08/a5", en8, data8);
    else n_pass++;
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    n_checks++;
    if ({en8, data8} !== {8'h00, 8'hA5}) $display("FAIL single_hold: got %h/%h want 00/a5", en8, data8);
    else n_pass++;
    @(negedge clk); req = 4'b0011; set_slot(1, 3'd1, 8'h11); #1;
    n_checks++;
    if (gnt8 !== 4'b0010) $display("FAIL single_ptr: got %b want 0010", gnt8); else n_pass++;
    @(negedge clk); req = '0;
  endtask

  task automatic test_fairness();
    int cnt [4];
    logic [3:0] eg;
    logic [7:0] ee;
    logic [7:0] ed;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      set_slot(i, 3'(i), 8'(8'h10 * (i + 1)));
    end
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      eg = 4'(1 << (c % 4));
      ee = 8'(1 << (c % 4));
      ed = 8'(8'h10 * (c % 4 + 1));
      for (int i = 0; i < 4; i++) if (gnt8[i]) cnt[i]++;
      n_checks++;
      if (gnt8 !== eg) $display("FAIL fair_gnt[%0d]: got %b want %b", c, gnt8, eg); else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({en8, data8} !== {ee, ed}) $display("FAIL fair_write[%0d]: got %h/%h want %h/%h", c, en8, data8, ee, ed);
      else n_pass++;
      @(negedge clk);
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cnt[i] !== 2) $display("FAIL fair_count[%0d]: got %0d want 2", i, cnt[i]); else n_pass++;
    end
  endtask

  task automatic test_lock();
    reset_dut();
    req = 4'b0110; req_lock = 4'b0010; set_slot(1, 3'd5, 8'hB1); set_slot(2, 3'd6, 8'hC2);
    for (int t = 0; t < 3; t++) begin
      #1;
      n_checks++;
      if ({gnt8, locked8} !== {4'b0010, (t != 0)})
        $display("FAIL lock_gnt[%0d]: got %b/%b want 0010/%b", t, gnt8, locked8, (t != 0));
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({en8, locked8} !== {8'h20, 1'b1}) $display("FAIL lock_write[%0d]: got %h/%b want 20/1", t, en8, locked8);
      else n_pass++;
      @(negedge clk);
    end
    req_lock = 4'b0000; #1;
    n_checks++;
    if ({gnt8, locked8} !== {4'b0010, 1'b1}) $display("FAIL lock_last: got %b/%b want 0010/1", gnt8, locked8);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (locked8 !== 1'b0) $display("FAIL lock_release: got %b want 0", locked8); else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (gnt8 !== 4'b0100) $display("FAIL lock_next: got %b want 0100", gnt8); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({en8, data8} !== {8'h40, 8'hC2}) $display("FAIL lock_next_write: got %h/%h want 40/c2", en8, data8);
    else n_pass++;
    @(negedge clk); req = 4'b1001; req_lock = 4'b1000; set_slot(3, 3'd7, 8'hD3); set_slot(0, 3'd0, 8'h0E); #1;
    n_checks++;
    if (gnt8 !== 4'b1000) $display("FAIL lock3_gnt: got %b want 1000", gnt8); else n_pass++;
    @(negedge clk); req = 4'b0001; #1;
    n_checks++;
    if ({gnt8, locked8} !== {4'b0000, 1'b1}) $display("FAIL abandon_block: got %b/%b want 0000/1", gnt8, locked8);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({locked8, en8} !== {1'b0, 8'h00}) $display("FAIL abandon_release: got %b/%h want 0/00", locked8, en8);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (gnt8 !== 4'b0001) $display("FAIL abandon_ptr: got %b want 0001", gnt8); else n_pass++;
    @(negedge clk); req = '0; req_lock = 4'b1111;
    @(posedge clk); #1;
    n_checks++;
    if (locked8 !== 1'b0) $display("FAIL lock_without_req: got %b want 0", locked8); else n_pass++;
    @(negedge clk); req_lock = '0;
  endtask

  task automatic test_bad_addr();
    reset_dut();
    req = 4'b0001; set_slot(0, 3'd7, 8'h5A); #1;
    n_checks++;
    if (gnt6 !== 4'b0001) $display("FAIL bad_gnt: got %b want 0001", gnt6); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({en6, en8} !== {6'b000000, 8'h80}) $display("FAIL bad_drop: got %b/%h want 000000/80", en6, en8);
    else n_pass++;
    @(negedge clk); req = 4'b0011; set_slot(1, 3'd5, 8'h66); #1;
    n_checks++;
    if (gnt6 !== 4'b0010) $display("FAIL bad_ptr: got %b want 0010", gnt6); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({en6, data6} !== {6'b100000, 8'h66}) $display("FAIL top_index: got %b/%h want 100000/66", en6, data6);
    else n_pass++;
    @(negedge clk); req = '0;
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    req = 4'b0010; req_lock = 4'b0010; set_slot(1, 3'd1, 8'h77);
    @(posedge clk); #1;
    n_checks++;
    if (locked8 !== 1'b1) $display("FAIL burst_locked: got %b want 1", locked8); else n_pass++;
    @(posedge clk); #3;
    rst_n = 1'b0; req = 4'b1111; req_lock = '0; #1;
    n_checks++;
    if ({locked8, en8} !== {1'b0, 8'h00}) $display("FAIL burst_reset: got %b/%h want 0/00", locked8, en8);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (gnt8 !== 4'b0001) $display("FAIL burst_after: got %b want 0001", gnt8); else n_pass++;
    @(negedge clk); req = '0;
  endtask

  task automatic test_random();
    bit         h_req [4];
    bit         h_lock[4];
    int         h_addr[4];
    int         h_data[4];
    bit         g_last[4];
    int         m_ptr, m_owner, k;
    bit         m_locked;
    logic [3:0] eg;
    logic [7:0] ee8, ed;
    logic [5:0] ee6;
    reset_dut();
    m_ptr = 0; m_owner = 0; m_locked = 1'b0; ed = 8'h00;
    for (int i = 0; i < 4; i++) begin h_req[i] = 1'b0; g_last[i] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      // A waiting requester keeps its request unchanged until it is granted.
      for (int i = 0; i < 4; i++) begin
        if (!(h_req[i] && !g_last[i])) begin
          h_req[i]  = ($urandom_range(0, 99) < 55);
          h_lock[i] = ($urandom_range(0, 3) == 0);
          h_addr[i] = $urandom_range(0, 7);
          h_data[i] = $urandom_range(0, 255);
        end
        req[i] = h_req[i]; req_lock[i] = h_lock[i];
        set_slot(i, 3'(h_addr[i]), 8'(h_data[i]));
      end
      #1;
      k = -1;
      if (!m_locked) begin
        for (int j = 0; j < 4; j++) if (k < 0 && h_req[(m_ptr + j) % 4]) k = (m_ptr + j) % 4;
      end else if (h_req[m_owner]) k = m_owner;
      eg = (k >= 0) ? 4'(1 << k) : 4'b0000;
      n_checks++;
      if ({gnt8, gnt6, locked8} !== {eg, eg, m_locked})
        $display("FAIL rand_gnt[%0d]: got %b/%b/%b want %b/%b/%b", c, gnt8, gnt6, locked8, eg, eg, m_locked);
      else n_pass++;
      ee8 = '0; ee6 = '0;
      if (k >= 0) begin
        ee8 = 8'(1 << h_addr[k]);
        ee6 = (h_addr[k] < 6) ? 6'(1 << h_addr[k]) : 6'b0;
        ed  = 8'(h_data[k]);
        if (!m_locked) begin
          if (h_lock[k]) begin m_locked = 1'b1; m_owner = k; end
          else m_ptr = (k + 1) % 4;
        end else if (!h_lock[k]) begin
          m_locked = 1'b0; m_ptr = (k + 1) % 4;
        end
      end else if (m_locked) begin
        m_locked = 1'b0; m_ptr = (m_owner + 1) % 4;
      end
      for (int i = 0; i < 4; i++) g_last[i] = (i == k);
      @(posedge clk); #1;
      n_checks++;
      if ({en8, en6, data8, data6, locked8} !== {ee8, ee6, ed, ed, m_locked})
        $display("FAIL rand_write[%0d]: got %h/%b/%h/%h/%b want %h/%b/%h/%h/%b",
                 c, en8, en6, data8, data6, locked8, ee8, ee6, ed, ed, m_locked);
      else n_pass++;
      @(negedge clk);
    end
    req = '0; req_lock = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req = '0; req_lock = '0; req_addr = '0; req_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_bad_addr();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
